chip8_fetch_sequencer: RTL and testbench

//  Sequences the CHIP-8 instruction cycle: on each timer_cpu_tick, fetches two bytes (big-endian) at pc/pc+1

---
 rtl/chip8_fetch_sequencer.sv | 179 +++++++++++++++++
 tb/tb_chip8_fetch_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_fetch_sequencer.sv
// rtl/chip8_fetch_sequencer.sv - CHIP-8 instruction fetch/execute sequencer
//
// Purpose: on each CPU tick, reads the big-endian opcode at pc/pc+1 from the
// shared byte-wide program memory, hands it to the execute unit and then
// updates pc (load, skip or advance) once execution is done.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   timer_cpu_tick_i      one-cycle pulse requesting one instruction
//   mem_req_o/mem_addr_o  registered read request and address to the arbiter
//   mem_gnt_i             arbiter accepted the request this cycle
//   mem_rdata_i           read byte, valid MEM_LAT cycles after the grant cycle
//   instruction_o         last fetched opcode {byte@pc, byte@pc+1}
//   exec_start_o          one-cycle pulse: instruction_o is valid, execute it
//   exec_done_i           execute finished; pc_load_i/pc_load_val_i/skip_i valid
//   pc_o                  current program counter
//   busy_o                sequencer is not idle
//   overrun_cnt_o         ticks lost while busy, saturating at 255

module chip8_fetch_sequencer #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = 12'h200,
    parameter int                MEM_LAT  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              timer_cpu_tick_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic [7:0]        mem_rdata_i,
    output logic [15:0]       instruction_o,
    output logic              exec_start_o,
    input  logic              exec_done_i,
    input  logic              pc_load_i,
    input  logic [ADDR_W-1:0] pc_load_val_i,
    input  logic              skip_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic [7:0]        overrun_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        HI_REQ,
        HI_WAIT,
        LO_REQ,
        LO_WAIT,
        EXEC,
        WAIT_DONE
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_req_q;
    logic              exec_start_q;
    logic [15:0]       instruction_q;
    logic [7:0]        hi_q;
    logic [2:0]        lat_cnt_q;
    logic              pending_q;
    logic [7:0]        overrun_cnt_q;
    logic              done_ok;

    // pc after an accepted exec_done; a jump beats a skip.
    always_comb begin
        pc_d = pc_q + ADDR_W'(2);
        if (pc_load_i) begin
            pc_d = pc_load_val_i;
        end else if (skip_i) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign done_ok  = exec_done_i && ((state_q == EXEC) || (state_q == WAIT_DONE));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            mem_addr_q    <= '0;
            mem_req_q     <= 1'b0;
            exec_start_q  <= 1'b0;
            instruction_q <= 16'h0000;
            hi_q          <= 8'h00;
            lat_cnt_q     <= 3'd0;
            pending_q     <= 1'b0;
            overrun_cnt_q <= 8'h00;
        end else begin
            exec_start_q <= 1'b0;

            // One tick may be queued while busy; any further ones are lost.
            // The cycle that returns to IDLE is still a busy cycle.
            if (timer_cpu_tick_i && (state_q != IDLE)) begin
                if (!pending_q) begin
                    pending_q <= 1'b1;
                end else if (overrun_cnt_q != 8'hFF) begin
                    overrun_cnt_q <= overrun_cnt_q + 8'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (timer_cpu_tick_i || pending_q) begin
                        pending_q  <= 1'b0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_q;
                        state_q    <= HI_REQ;
                    end
                end
                HI_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        lat_cnt_q <= 3'd1;
                        state_q   <= HI_WAIT;
                    end
                end
                HI_WAIT: begin
                    // lat_cnt_q equals the number of cycles since the grant cycle.
                    if (lat_cnt_q == LAT) begin
                        hi_q       <= mem_rdata_i;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_plus1;
                        state_q    <= LO_REQ;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end
                LO_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        lat_cnt_q <= 3'd1;
                        state_q   <= LO_WAIT;
                    end
                end
                LO_WAIT: begin
                    if (lat_cnt_q == LAT) begin
                        instruction_q <= {hi_q, mem_rdata_i};
                        exec_start_q  <= 1'b1;
                        state_q       <= EXEC;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end
                EXEC: begin
                    if (done_ok) begin
                        pc_q    <= pc_d;
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (done_ok) begin
                        pc_q    <= pc_d;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign instruction_o = instruction_q;
    assign exec_start_o  = exec_start_q;
    assign pc_o          = pc_q;
    assign busy_o        = (state_q != IDLE);
    assign overrun_cnt_o = overrun_cnt_q;

endmodule

// File: tb/tb_chip8_fetch_sequencer.sv
// tb/tb_chip8_fetch_sequencer.sv - self-checking bench for chip8_fetch_sequencer
module tb_chip8_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        exec_done;
    logic        pc_load;
    logic [11:0] pc_load_val;
    logic        skip;

    logic        mem_req     [2];
    logic [11:0] mem_addr    [2];
    logic        gnt         [2];
    logic [7:0]  rdata       [2];
    logic [15:0] instruction [2];
    logic        exec_start  [2];
    logic [11:0] pc          [2];
    logic        busy        [2];
    logic [7:0]  ovr         [2];

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chip8_fetch_sequencer #(.ADDR_W(12), .RESET_PC(12'h200), .MEM_LAT(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .timer_cpu_tick_i(tick),
        .mem_req_o(mem_req[0]), .mem_addr_o(mem_addr[0]), .mem_gnt_i(gnt[0]),
        .mem_rdata_i(rdata[0]), .instruction_o(instruction[0]), .exec_start_o(exec_start[0]),
        .exec_done_i(exec_done), .pc_load_i(pc_load), .pc_load_val_i(pc_load_val),
        .skip_i(skip), .pc_o(pc[0]), .busy_o(busy[0]), .overrun_cnt_o(ovr[0])
    );

    chip8_fetch_sequencer #(.ADDR_W(12), .RESET_PC(12'h200), .MEM_LAT(3)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .timer_cpu_tick_i(tick),
        .mem_req_o(mem_req[1]), .mem_addr_o(mem_addr[1]), .mem_gnt_i(gnt[1]),
        .mem_rdata_i(rdata[1]), .instruction_o(instruction[1]), .exec_start_o(exec_start[1]),
        .exec_done_i(exec_done), .pc_load_i(pc_load), .pc_load_val_i(pc_load_val),
        .skip_i(skip), .pc_o(pc[1]), .busy_o(busy[1]), .overrun_cnt_o(ovr[1])
    );

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s dut%0d @cyc %0d: got %h expected %h", nm, k, cyc, act, exp);
        end
    endtask

    // ---------------- memory model + transaction-level reference ----------------
    logic [7:0]  mem [4096];
    bit          rand_gnt;
    int          gdly  [2];
    int          wcnt  [2];
    int          due   [2];
    logic [11:0] daddr [2];

    bit          m_act    [2];
    bit          m_pend   [2];
    int          m_ovr    [2];
    logic [11:0] m_pc     [2];
    int          m_left   [2];
    logic [11:0] m_raddr  [2][2];
    int          m_req_from [2];
    int          m_exec_at  [2];
    logic [15:0] m_instr  [2];
    int          lo_gnts0 = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit exp_req;
            bit act_before;
            // memory: data exactly MEM_LAT cycles after the grant cycle, junk otherwise
            rdata[k] = (cyc == due[k]) ? mem[daddr[k]] : (8'hA5 ^ cyc[7:0]);
            if (rst) begin
                gnt[k]  = 1'b0;
                wcnt[k] = 0;
            end else if (mem_req[k]) begin
                if (wcnt[k] >= gdly[k]) begin
                    gnt[k]   = 1'b1;
                    due[k]   = cyc + lat_of(k);
                    daddr[k] = mem_addr[k];
                    wcnt[k]  = 0;
                    if (rand_gnt) gdly[k] = $urandom_range(0, 3);
                end else begin
                    gnt[k] = 1'b0;
                    wcnt[k]++;
                end
            end else begin
                gnt[k] = rand_gnt && ($urandom_range(0, 3) == 0);
            end

            if (rst) begin
                m_act[k] = 0; m_pend[k] = 0; m_ovr[k] = 0; m_pc[k] = 12'h200;
                m_left[k] = 0; m_req_from[k] = 0; m_exec_at[k] = -1; m_instr[k] = 16'h0000;
            end else begin
                exp_req = m_act[k] && (m_left[k] > 0) && (cyc >= m_req_from[k]);
                if (cyc == m_exec_at[k])
                    m_instr[k] = {mem[m_pc[k]], mem[m_pc[k] + 12'd1]};
                chk("busy", k, 32'(busy[k]), 32'(m_act[k]));
                chk("mem_req", k, 32'(mem_req[k]), 32'(exp_req));
                if (exp_req)
                    chk("mem_addr", k, 32'(mem_addr[k]), 32'(m_raddr[k][2 - m_left[k]]));
                chk("exec_start", k, 32'(exec_start[k]), 32'(cyc == m_exec_at[k]));
                chk("instruction", k, 32'(instruction[k]), 32'(m_instr[k]));
                chk("pc", k, 32'(pc[k]), 32'(m_pc[k]));
                chk("overrun_cnt", k, 32'(ovr[k]), 32'(m_ovr[k]));

                act_before = m_act[k];
                if (gnt[k] && exp_req) begin
                    if (m_left[k] == 2) begin
                        m_req_from[k] = cyc + lat_of(k) + 1;
                    end else begin
                        m_exec_at[k] = cyc + lat_of(k) + 1;
                        if (k == 0) lo_gnts0++;
                    end
                    m_left[k]--;
                end
                if (m_act[k] && m_exec_at[k] >= 0 && cyc >= m_exec_at[k] && exec_done) begin
                    m_pc[k] = pc_load ? pc_load_val : (skip ? m_pc[k] + 12'd4 : m_pc[k] + 12'd2);
                    m_act[k] = 0;
                    m_exec_at[k] = -1;
                end
                if (act_before) begin
                    if (tick) begin
                        if (!m_pend[k]) m_pend[k] = 1;
                        else if (m_ovr[k] < 255) m_ovr[k]++;
                    end
                end else if (tick || m_pend[k]) begin
                    m_act[k] = 1; m_pend[k] = 0; m_left[k] = 2;
                    m_raddr[k][0] = m_pc[k];
                    m_raddr[k][1] = m_pc[k] + 12'd1;
                    m_req_from[k] = cyc + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_exec(output int n0);
        bit seen0 = 0, seen1 = 0;
        int n = 0;
        n0 = -1;
        while (!(seen0 && seen1) && n < 200) begin
            @(negedge clk);
            n++;
            if (exec_start[0] && !seen0) begin seen0 = 1; n0 = n; end
            if (exec_start[1]) seen1 = 1;
        end
        chk("exec_timeout", 0, 32'(seen0 && seen1), 32'd1);
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
    endtask

    task automatic pulse_done(input logic ld, input logic [11:0] val, input logic sk);
        @(posedge clk); #1 exec_done = 1'b1; pc_load = ld; pc_load_val = val; skip = sk;
        @(posedge clk); #1 exec_done = 1'b0; pc_load = 1'b0; skip = 1'b0;
    endtask

    task automatic do_instr(input logic ld, input logic [11:0] val, input logic sk, output int n0);
        pulse_tick();
        wait_exec(n0);
        pulse_done(ld, val, sk);
    endtask

    typedef struct {
        logic        ld;
        logic [11:0] val;
        logic        sk;
        logic [11:0] exp_pc;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int n0;
        int start;
        bit found;
        tbl[0]  = '{1'b1, 12'h456, 1'b0, 12'h456};
        tbl[1]  = '{1'b1, 12'h300, 1'b0, 12'h300};
        tbl[2]  = '{1'b0, 12'h000, 1'b1, 12'h304};
        tbl[3]  = '{1'b1, 12'h300, 1'b1, 12'h300};
        tbl[4]  = '{1'b0, 12'h000, 1'b0, 12'h302};
        tbl[5]  = '{1'b1, 12'hFFE, 1'b0, 12'hFFE};
        tbl[6]  = '{1'b0, 12'h000, 1'b0, 12'h000};
        tbl[7]  = '{1'b1, 12'hFFC, 1'b1, 12'hFFC};
        tbl[8]  = '{1'b0, 12'h000, 1'b1, 12'h000};
        tbl[9]  = '{1'b1, 12'hFFF, 1'b0, 12'hFFF};
        tbl[10] = '{1'b0, 12'h000, 1'b0, 12'h001};
        tbl[11] = '{1'b1, 12'h200, 1'b0, 12'h200};

        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h200] = 8'h12;
        mem[12'h201] = 8'h34;
        rst = 1'b1; tick = 1'b0; exec_done = 1'b0; pc_load = 1'b0; pc_load_val = '0; skip = 1'b0;
        rand_gnt = 0; gdly[0] = 0; gdly[1] = 3; wcnt[0] = 0; wcnt[1] = 0; due[0] = -10; due[1] = -10;
        daddr[0] = '0; daddr[1] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_pc", k, 32'(pc[k]), 32'h200);
            chk("rst_busy", k, 32'(busy[k]), 32'd0);
            chk("rst_mem_req", k, 32'(mem_req[k]), 32'd0);
            chk("rst_mem_addr", k, 32'(mem_addr[k]), 32'd0);
            chk("rst_exec_start", k, 32'(exec_start[k]), 32'd0);
            chk("rst_instruction", k, 32'(instruction[k]), 32'd0);
            chk("rst_overrun", k, 32'(ovr[k]), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // basic fetch latency and opcode, then the pc-update table
        pulse_tick();
        wait_exec(n0);
        chk("latency", 0, 32'(n0), 32'd5);
        chk("first_opcode", 0, 32'(instruction[0]), 32'h1234);
        chk("first_opcode", 1, 32'(instruction[1]), 32'h1234);
        pulse_done(tbl[0].ld, tbl[0].val, tbl[0].sk);
        chk("tbl_pc", 0, 32'(pc[0]), 32'(tbl[0].exp_pc));
        for (int i = 1; i < 12; i++) begin
            do_instr(tbl[i].ld, tbl[i].val, tbl[i].sk, n0);
            chk("tbl_pc", 0, 32'(pc[0]), 32'(tbl[i].exp_pc));
            chk("tbl_pc", 1, 32'(pc[1]), 32'(tbl[i].exp_pc));
        end

        // ticks while busy: one pends, the rest count as overruns
        pulse_tick();
        wait_exec(n0);
        repeat (3) pulse_tick();
        @(negedge clk);
        chk("overrun3", 0, 32'(ovr[0]), 32'd2);
        chk("overrun3", 1, 32'(ovr[1]), 32'd2);
        pulse_done(1'b0, 12'h000, 1'b0);
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (mem_req[0]) found = 1;
        end
        chk("pending_restart", 0, 32'(found), 32'd1);
        wait_exec(n0);
        repeat (300) pulse_tick();
        @(negedge clk);
        chk("overrun_sat", 0, 32'(ovr[0]), 32'd255);
        chk("overrun_sat", 1, 32'(ovr[1]), 32'd255);
        pulse_done(1'b0, 12'h000, 1'b0);
        wait_exec(n0);
        pulse_done(1'b0, 12'h000, 1'b0);
        chk("pc_before_rst", 0, 32'(pc[0]), 32'h206);

        // reset in LO_WAIT with the low byte still in flight
        pulse_tick();
        start = lo_gnts0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            if (lo_gnts0 != start) found = 1;
        end
        chk("lo_grant_seen", 0, 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_req", k, 32'(mem_req[k]), 32'd0);
            chk("async_rst_busy", k, 32'(busy[k]), 32'd0);
            chk("async_rst_pc", k, 32'(pc[k]), 32'h200);
            chk("async_rst_ovr", k, 32'(ovr[k]), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        do_instr(1'b0, 12'h000, 1'b0, n0);
        chk("post_rst_opcode", 0, 32'(instruction[0]), 32'h1234);
        chk("post_rst_pc", 0, 32'(pc[0]), 32'h202);

        // randomized traffic checked cycle by cycle against the reference
        rand_gnt = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            tick        = ($urandom_range(0, 7) == 0);
            exec_done   = ($urandom_range(0, 3) == 0);
            pc_load     = ($urandom_range(0, 2) == 0);
            skip        = 1'($urandom_range(0, 1));
            pc_load_val = 12'($urandom);
        end
        @(posedge clk); #1 tick = 1'b0; exec_done = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
